// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sprite geometry defaults and palette index type
package sprite_pkg;
    localparam int SPR_W     = 32;
    localparam int SPR_H     = 48;
    localparam int N_FRAMES  = 4;
    localparam int ANIM_DIV  = 8;
    localparam int ADDR_W    = 13;
    localparam int FRAME_PIX = SPR_W * SPR_H;

    typedef logic [4:0] pal_idx_t;
endpackage

// File: rtl/sprite_fetch_edge_sync.sv
// rtl/sprite_fetch_edge_sync.sv - 2-flop synchronizer with registered rising-edge pulse
module edge_sync (
    input  logic Clk,
    input  logic Reset_n,
    input  logic async_i,
    output logic pulse_o
);
    logic meta_q, sync_q, prev_q, pulse_q;

    // Pulse lands three Clk edges after the async rise, one cycle wide.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= async_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;
endmodule

// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - player sprite box test, ROM addressing and 2-stage output pipeline
module sprite_fetch #(
    parameter  int SPR_W    = sprite_pkg::SPR_W,
    parameter  int SPR_H    = sprite_pkg::SPR_H,
    parameter  int N_FRAMES = sprite_pkg::N_FRAMES,
    parameter  int ANIM_DIV = sprite_pkg::ANIM_DIV,
    parameter  int ADDR_W   = sprite_pkg::ADDR_W,
    localparam int AF_W     = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic                 moving,
    input  logic                 facing_left,
    input  logic [9:0]           DrawX,
    input  logic [9:0]           DrawY,
    output logic [ADDR_W-1:0]    rom_addr,
    input  sprite_pkg::pal_idx_t rom_q,
    output logic                 is_player,
    output sprite_pkg::pal_idx_t stand_data_out,
    output logic [9:0]           DrawX_o,
    output logic [9:0]           DrawY_o,
    output logic [AF_W-1:0]      anim_frame
);
    localparam int DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int FRAME_PIX = SPR_W * SPR_H;

    logic frame_tick;

    edge_sync u_frame_sync (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .async_i (frame_clk),
        .pulse_o (frame_tick)
    );

    logic [9:0]       px_q, py_q;
    logic             flip_q;
    logic [DIV_W-1:0] div_q;
    logic [AF_W-1:0]  anim_q;

    // Shadow copies only move on the frame tick so a frame never tears.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            px_q   <= '0;
            py_q   <= '0;
            flip_q <= 1'b0;
            div_q  <= '0;
            anim_q <= '0;
        end else if (frame_tick) begin
            px_q   <= pos_x;
            py_q   <= pos_y;
            flip_q <= facing_left;
            if (!moving) begin
                div_q  <= '0;
                anim_q <= '0;
            end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                div_q  <= '0;
                anim_q <= (anim_q == AF_W'(N_FRAMES - 1)) ? '0 : anim_q + AF_W'(1);
            end else begin
                div_q  <= div_q + DIV_W'(1);
            end
        end
    end

    logic [10:0]       x11, y11, px11, py11, dx, dy, col;
    logic              hit_d;
    logic [ADDR_W-1:0] rom_addr_d;

    // 11-bit arithmetic keeps a box hanging past X=1023 from wrapping to low X.
    always_comb begin
        x11        = {1'b0, DrawX};
        y11        = {1'b0, DrawY};
        px11       = {1'b0, px_q};
        py11       = {1'b0, py_q};
        dx         = x11 - px11;
        dy         = y11 - py11;
        hit_d      = (x11 >= px11) && (x11 < px11 + 11'(SPR_W)) &&
                     (y11 >= py11) && (y11 < py11 + 11'(SPR_H));
        col        = flip_q ? (11'(SPR_W - 1) - dx) : dx;
        rom_addr_d = '0;
        if (hit_d) begin
            rom_addr_d = ADDR_W'(anim_q) * ADDR_W'(FRAME_PIX)
                       + ADDR_W'(dy) * ADDR_W'(SPR_W)
                       + ADDR_W'(col);
        end
    end

    logic [ADDR_W-1:0]    rom_addr_q;
    logic                 hit_d1_q, is_player_q;
    logic [9:0]           drawx_d1_q, drawy_d1_q, drawx_o_q, drawy_o_q;
    sprite_pkg::pal_idx_t stand_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr_q  <= '0;
            hit_d1_q    <= 1'b0;
            drawx_d1_q  <= '0;
            drawy_d1_q  <= '0;
            is_player_q <= 1'b0;
            stand_q     <= '0;
            drawx_o_q   <= '0;
            drawy_o_q   <= '0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            hit_d1_q    <= hit_d;
            drawx_d1_q  <= DrawX;
            drawy_d1_q  <= DrawY;
            is_player_q <= hit_d1_q;
            stand_q     <= hit_d1_q ? rom_q : '0;
            drawx_o_q   <= drawx_d1_q;
            drawy_o_q   <= drawy_d1_q;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign is_player      = is_player_q;
    assign stand_data_out = stand_q;
    assign DrawX_o        = drawx_o_q;
    assign DrawY_o        = drawy_o_q;
    assign anim_frame     = anim_q;
endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Per-pixel sprite source for the player layer; sits directly upstream of the colour mapper.
- Latches the player position, facing direction and animation frame once per video frame.
- Tests the current scan pixel against the sprite box and drives the sprite ROM address.
- Returns a pipelined hit flag plus 5-bit palette index, aligned with delayed scan coordinates, for the colour mapper to look up.

Parameters:
- SPR_W, 32, sprite width in pixels (power of two)
- SPR_H, 48, sprite height in pixels
- N_FRAMES, 4, animation frames stored consecutively in ROM (power of two)
- ANIM_DIV, 8, video frames per animation step
- ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H*N_FRAMES

Ports:
- Clk  in  1  pixel-domain clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  vertical-sync-derived frame strobe; asynchronous to Clk
- pos_x  in  10  sprite top-left X from movement logic
- pos_y  in  10  sprite top-left Y
- moving  in  1  player walking; enables animation
- facing_left  in  1  horizontal mirror request
- DrawX  in  10  current scan X
- DrawY  in  10  current scan Y
- rom_addr  out  ADDR_W  synchronous sprite ROM address
- rom_q  in  5  ROM palette index; valid 1 cycle after rom_addr
- is_player  out  1  pixel lies inside the sprite box
- stand_data_out  out  5  palette index; 0 = transparent
- DrawX_o  out  10  DrawX delayed to match outputs
- DrawY_o  out  10  DrawY delayed to match outputs
- anim_frame  out  log2(N_FRAMES)  current animation frame

Behaviour:
- Reset (Reset_n=0, asynchronous): every register and output is cleared to 0. This includes the synchronizer, shadow position/facing, animation divider, anim_frame, rom_addr, the hit pipeline, is_player, stand_data_out, DrawX_o and DrawY_o.
- Frame tick:
  - frame_clk passes through a 2-flop synchronizer and a rising-edge detector, producing frame_tick (1 cycle wide).
  - frame_tick is asserted 3 Clk cycles after the frame_clk rise; a held-high frame_clk yields exactly one tick.
- Shadow registers:
  - On frame_tick, px<=pos_x, py<=pos_y and flip<=facing_left.
  - Between ticks, changes on these inputs are ignored (tear-free).
  - A tick coinciding with an in-box pixel: that pixel uses the old shadow values; new values apply from the next cycle.
- Animation, evaluated on frame_tick only:
  - moving=0: divider<=0, anim_frame<=0.
  - moving=1, divider==ANIM_DIV-1: divider<=0, anim_frame<=anim_frame+1, wrapping N_FRAMES-1 -> 0.
  - moving=1 otherwise: divider increments.
- Stage 0 (combinational):
  - dx = DrawX-px and dy = DrawY-py, computed at 11 bits.
  - hit = (DrawX>=px) && (DrawX<px+SPR_W) && (DrawY>=py) && (DrawY<py+SPR_H).
  - Bounds use 11-bit sums, so a box extending past X=1023 neither wraps nor hits at low X.
  - col = flip ? SPR_W-1-dx : dx.
  - addr = anim_frame*SPR_W*SPR_H + dy*SPR_W + col, truncated to ADDR_W.
- Stage 1 (registered):
  - rom_addr <= hit ? addr : 0.
  - hit_d1 <= hit.
  - DrawX/DrawY are delayed one stage.
- Stage 2 (registered, sampling rom_q):
  - is_player <= hit_d1.
  - stand_data_out <= hit_d1 ? rom_q : 0.
  - DrawX_o/DrawY_o carry the 2-cycle-delayed coordinates.
- Latency: a pixel presented at cycle n appears on the outputs at n+2, with throughput 1 pixel/cycle.
- Boundaries:
  - px=0 and DrawX=0 is a hit.
  - DrawX=px+SPR_W-1 is the last hit column; DrawX=px+SPR_W is a miss.
  - The last row is likewise the final hit.
- Reset mid-frame: outputs clear immediately; the shadow position stays 0 (box at origin) until the next frame_tick.
- No internal ROM: a 1-cycle synchronous external ROM is required.

Decomposition:
- Package sprite_pkg holds:
  - SPR_W, SPR_H, N_FRAMES and ANIM_DIV defaults
  - pal_idx_t (logic [4:0])
  - FRAME_PIX = SPR_W*SPR_H
- One sub-module, edge_sync: a 2-flop synchronizer plus rising-edge pulse generator, with the same Clk/Reset_n.
- Expected size: ~180 RTL lines.

Test Plan:
- Reset: Reset_n=0 mid-stream -> all outputs 0 asynchronously. Release, then pos=(100,50) without frame_clk; DrawX=10, DrawY=10 -> is_player=1 (box still at origin). DrawX=200 -> is_player=0.
- Position latch: pos=(100,50), pulse frame_clk. Scan (100,50) -> at n+2 is_player=1, rom_addr was 0 at n+1, stand_data_out=rom_q. (131,50) -> hit, rom_addr=31. (132,50) -> is_player=0, stand_data_out=0. (100,97) -> hit, rom_addr=47*32=1504. (100,98) -> miss.
- Mirror: facing_left=1 plus tick; scan (100,50) -> rom_addr=31; (131,50) -> rom_addr=0. Toggling facing_left without a tick -> no change.
- Animation: moving=1, 8 ticks -> anim_frame=1; scan (100,50) -> rom_addr=1536. 32 ticks -> anim_frame wraps to 0. moving=0 with one tick -> anim_frame=0, divider cleared.
- Edge wrap: pos_x=1010 plus tick; DrawX=1023 -> hit, dx=13; DrawX=0..5 -> is_player=0.
- Alignment: DrawX ramp 0..639 -> DrawX_o equals DrawX delayed exactly 2 cycles; one frame_clk held high for 100 cycles -> exactly one frame_tick.
